fifo_counted: RTL and testbench

Synchronous single-clock FIFO that supersedes the basic fifo block.
- Exact occupancy count, so all DATA_DEPTH entries are usable.
- Programmable almost-full and almost-empty thresholds.
- Sticky overflow and underflow error flags.
- Defined read/write behaviour when full and when empty.
Used as the general buffering primitive between streaming stages in the datapath.

---
 rtl/fifo_counted.sv | 121 ++++++++++++
 tb/tb_fifo_counted.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_counted.sv
// Single-clock FIFO with exact occupancy count, programmable almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default is registered reads with 1-cycle latency.
module fifo_counted #(
  parameter int DATA_WIDTH    = 16,
  parameter int DATA_DEPTH    = 8,
  parameter int AFULL_THRESH  = DATA_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [DATA_WIDTH-1:0]           write_data_i,
  input  logic                            rd_en_i,
  output logic [DATA_WIDTH-1:0]           read_data_o,
  output logic                            read_valid_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o,
  output logic [$clog2(DATA_DEPTH+1)-1:0] count_o,
  output logic                            overflow_o,
  output logic                            underflow_o,
  input  logic                            clr_err_i
);

  localparam int PTR_W = $clog2(DATA_DEPTH);
  localparam int CNT_W = $clog2(DATA_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow_q;
  logic                  underflow_q;

  // Handshake: wr_en_i/rd_en_i are requests with no ready output. A request
  // is accepted in the cycle it is high if the FIFO can take it (a write into
  // a full FIFO is taken only alongside an accepted read); a request that is
  // not accepted has no effect on storage and raises the matching sticky flag.
  assign rd_acc = rd_en_i & (count != '0);
  assign wr_acc = wr_en_i & ((count != DEPTH_CNT) | rd_acc);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; reset only forgets what it held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) mem[wr_ptr] <= write_data_i;
  end

  // Setting an error wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en_i && !wr_acc) overflow_q <= 1'b1;
      else if (clr_err_i)     overflow_q <= 1'b0;
      if (rd_en_i && !rd_acc) underflow_q <= 1'b1;
      else if (clr_err_i)     underflow_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head of queue is presented directly; rd_en_i acknowledges it.
  assign read_data_o  = (count != '0) ? mem[rd_ptr] : '0;
  assign read_valid_o = (count != '0);
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr];
    end
  end

  assign read_data_o  = rd_data_q;
  assign read_valid_o = rd_valid_q;
`endif

  assign count_o        = count;
  assign empty_o        = (count == '0);
  assign full_o         = (count == DEPTH_CNT);
  assign almost_full_o  = (count >= AFULL_CNT);
  assign almost_empty_o = (count <= AEMPTY_CNT);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  count_in_range: assert property (@(posedge clk_i) disable iff (rst_i) count <= DEPTH_CNT);
  ptrs_in_range:  assert property (@(posedge clk_i) disable iff (rst_i) (wr_ptr <= LAST_PTR) && (rd_ptr <= LAST_PTR));

endmodule

// File: tb/tb_fifo_counted.sv
// Directed bench for fifo_counted (DATA_DEPTH=8); covers both read modes via FIFO_FWFT_EN.
module tb_fifo_counted;
  localparam int DW = 16;
  localparam int DD = 8;

  logic          clk_i = 1'b0;
  logic          rst_i, wr_en_i, rd_en_i, clr_err_i;
  logic [DW-1:0] write_data_i;
  logic [DW-1:0] read_data_o;
  logic          read_valid_o, empty_o, full_o, almost_full_o, almost_empty_o;
  logic [3:0]    count_o;
  logic          overflow_o, underflow_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] exp_q[$];

  fifo_counted #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .write_data_i(write_data_i),
    .rd_en_i(rd_en_i), .read_data_o(read_data_o), .read_valid_o(read_valid_o),
    .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o), .clr_err_i(clr_err_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; clr_err_i = 1'b0; write_data_i = '0;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  // driver: push words base..base+n-1 and record them in the scoreboard
  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en_i = 1'b1; write_data_i = base + DW'(i);
      exp_q.push_back(write_data_i);
      tick();
    end
    wr_en_i = 1'b0;
  endtask

  // driver + scoreboard: pop n words back to back and compare against exp_q
  task automatic drain(input int n, input string tag);
    logic [DW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      rd_en_i = 1'b1;
      if (exp_q.size() == 0) begin
        err_cnt++; $display("FAIL %s_scoreboard: expected queue empty at pop %0d", tag, i);
        exp = '0;
      end else exp = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
      vec_cnt++;
      if (read_valid_o !== 1'b1 || read_data_o !== exp) begin
        err_cnt++; $display("FAIL %s_data[%0d]: got %h/v%b want %h/v1", tag, i, read_data_o, read_valid_o, exp);
      end
      tick();
`else
      tick();
      vec_cnt++;
      if (read_valid_o !== 1'b1 || read_data_o !== exp) begin
        err_cnt++; $display("FAIL %s_data[%0d]: got %h/v%b want %h/v1", tag, i, read_data_o, read_valid_o, exp);
      end
`endif
    end
    rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    tick();
    vec_cnt++;
    if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin
      err_cnt++; $display("FAIL reset_flags: got e%b ae%b f%b af%b want e1 ae1 f0 af0", empty_o, almost_empty_o, full_o, almost_full_o);
    end
    vec_cnt++;
    if (count_o !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", count_o); end
    vec_cnt++;
    if ({read_valid_o, overflow_o, underflow_o} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_status: got v%b ov%b un%b want 000", read_valid_o, overflow_o, underflow_o);
    end
    vec_cnt++;
    if (read_data_o !== 16'h0000) begin err_cnt++; $display("FAIL reset_data: got %h want 0000", read_data_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DD; i++) begin
      wr_en_i = 1'b1; write_data_i = 16'h1000 + DW'(i);
      exp_q.push_back(write_data_i);
      tick();
      vec_cnt++;
      if (count_o !== 4'(i + 1) || almost_full_o !== (i + 1 >= 6) || full_o !== (i + 1 == DD)) begin
        err_cnt++;
        $display("FAIL fill_step[%0d]: got cnt %0d af%b f%b want cnt %0d af%b f%b",
                 i, count_o, almost_full_o, full_o, i + 1, (i + 1 >= 6), (i + 1 == DD));
      end
    end
    write_data_i = 16'hDEAD;
    tick();
    wr_en_i = 1'b0;
    vec_cnt++;
    if (overflow_o !== 1'b1 || count_o !== 4'd8 || full_o !== 1'b1) begin
      err_cnt++; $display("FAIL overflow: got ov%b cnt %0d f%b want ov1 cnt 8 f1", overflow_o, count_o, full_o);
    end
    clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
    vec_cnt++;
    if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL overflow_clear: got %b want 0", overflow_o); end
  endtask

  task automatic test_drain_underflow();
    drain(DD, "drain");
    vec_cnt++;
    if (empty_o !== 1'b1 || count_o !== 4'd0) begin
      err_cnt++; $display("FAIL drain_empty: got e%b cnt %0d want e1 cnt 0", empty_o, count_o);
    end
`ifndef FIFO_FWFT_EN
    tick();
    vec_cnt++;
    if (read_valid_o !== 1'b0 || read_data_o !== 16'h1007) begin
      err_cnt++; $display("FAIL read_hold: got %h/v%b want 1007/v0", read_data_o, read_valid_o);
    end
`endif
    rd_en_i = 1'b1; tick(); rd_en_i = 1'b0;
    vec_cnt++;
    if (underflow_o !== 1'b1 || empty_o !== 1'b1 || read_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL underflow: got un%b e%b v%b want un1 e1 v0", underflow_o, empty_o, read_valid_o);
    end
    clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    reset_dut();
    write_words(16'h1000, DD);
    for (int i = 0; i < 4; i++) begin
      wr_en_i = 1'b1; rd_en_i = 1'b1; write_data_i = 16'h2000 + DW'(i);
      exp_q.push_back(write_data_i);
      exp = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
      vec_cnt++;
      if (read_data_o !== exp) begin err_cnt++; $display("FAIL b2b_data[%0d]: got %h want %h", i, read_data_o, exp); end
      tick();
`else
      tick();
      vec_cnt++;
      if (read_data_o !== exp || read_valid_o !== 1'b1) begin
        err_cnt++; $display("FAIL b2b_data[%0d]: got %h/v%b want %h/v1", i, read_data_o, read_valid_o, exp);
      end
`endif
      vec_cnt++;
      if (count_o !== 4'd8 || overflow_o !== 1'b0) begin
        err_cnt++; $display("FAIL b2b_count[%0d]: got cnt %0d ov%b want cnt 8 ov0", i, count_o, overflow_o);
      end
    end
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    drain(DD, "wrap");
  endtask

  task automatic test_empty_rw();
    write_data_i = 16'hABCD; wr_en_i = 1'b1; rd_en_i = 1'b1;
    exp_q.push_back(write_data_i);
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    vec_cnt++;
    if (count_o !== 4'd1 || underflow_o !== 1'b1) begin
      err_cnt++; $display("FAIL empty_rw: got cnt %0d un%b want cnt 1 un1", count_o, underflow_o);
    end
`ifdef FIFO_FWFT_EN
    vec_cnt++;
    if (read_valid_o !== 1'b1) begin err_cnt++; $display("FAIL empty_rw_valid: got %b want 1", read_valid_o); end
`else
    vec_cnt++;
    if (read_valid_o !== 1'b0) begin err_cnt++; $display("FAIL empty_rw_valid: got %b want 0", read_valid_o); end
`endif
    clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
    vec_cnt++;
    if (underflow_o !== 1'b0) begin err_cnt++; $display("FAIL underflow_clear: got %b want 0", underflow_o); end
    drain(1, "empty_rw");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    write_words(16'h3000, 3);
    rst_i = 1'b1; wr_en_i = 1'b1; write_data_i = 16'h3333;
    tick();
    rst_i = 1'b0; wr_en_i = 1'b0;
    exp_q.delete();
    vec_cnt++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0 || read_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid: got cnt %0d e%b ov%b un%b v%b want cnt 0 e1 ov0 un0 v0",
                          count_o, empty_o, overflow_o, underflow_o, read_valid_o);
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    write_words(16'h5A5A, 1);
    vec_cnt++;
    if (read_data_o !== 16'h5A5A || read_valid_o !== 1'b1) begin
      err_cnt++; $display("FAIL fwft_present: got %h/v%b want 5a5a/v1", read_data_o, read_valid_o);
    end
    drain(1, "fwft");
    vec_cnt++;
    if (read_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      err_cnt++; $display("FAIL fwft_after_pop: got v%b e%b want v0 e1", read_valid_o, empty_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_empty_rw();
    test_reset_mid();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
